// File: rtl/blinky_pkg.sv
// Shared definitions for the LED mode sequencer: mode encodings, pattern
// timing constants and the pure next-mode / pattern helpers.
package blinky_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_SLOW  = 3'd1,
    MODE_FAST  = 3'd2,
    MODE_HEART = 3'd3,
    MODE_ON    = 3'd4
  } mode_t;

  // Phase runs over a 1000 ms period; all pattern windows are in ms.
  localparam int          PHASE_PERIOD    = 1000;
  localparam logic [9:0]  PHASE_LAST      = 10'(PHASE_PERIOD - 1);
  localparam logic [9:0]  SLOW_HALF       = 10'd500;
  localparam int          FAST_PERIOD     = 250;
  localparam logic [7:0]  FAST_LAST       = 8'(FAST_PERIOD - 1);
  localparam logic [7:0]  FAST_HALF       = 8'd125;
  localparam logic [9:0]  HEART_ON0_END   = 10'd100;
  localparam logic [9:0]  HEART_ON1_START = 10'd200;
  localparam logic [9:0]  HEART_ON1_END   = 10'd300;

  // Step to the following mode; unreachable codes fall back to OFF.
  function automatic logic [2:0] next_mode(input logic [2:0] cur);
    case (cur)
      MODE_OFF:   next_mode = MODE_SLOW;
      MODE_SLOW:  next_mode = MODE_FAST;
      MODE_FAST:  next_mode = MODE_HEART;
      MODE_HEART: next_mode = MODE_ON;
      default:    next_mode = MODE_OFF;
    endcase
  endfunction

  // LED level for a mode at a given phase; fast_cnt tracks phase mod 250.
  function automatic logic led_pattern(input logic [2:0] cur,
                                       input logic [9:0] phase,
                                       input logic [7:0] fast_cnt);
    case (cur)
      MODE_SLOW:  led_pattern = (phase < SLOW_HALF);
      MODE_FAST:  led_pattern = (fast_cnt < FAST_HALF);
      MODE_HEART: led_pattern = (phase < HEART_ON0_END) ||
                                ((phase >= HEART_ON1_START) && (phase < HEART_ON1_END));
      MODE_ON:    led_pattern = 1'b1;
      default:    led_pattern = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/blinky_debounce.sv
// Push-button front end: two-flop synchroniser, ms-quantised debounce
// window and a single-cycle press pulse on each debounced 0->1 change.
module blinky_debounce
  import blinky_pkg::*;
#(
  parameter int debounce_ms = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic btn,
  output logic press
);

  localparam logic [7:0] CNT_LAST = 8'(debounce_ms - 1);

  logic       sync1;
  logic       btn_s;
  logic       stable;
  logic [7:0] cnt;
  logic       window_done;

  // Window completes on the tick where the mismatch has lasted debounce_ms ticks.
  assign window_done = tick_ms && (btn_s != stable) && (cnt == CNT_LAST);
  // Combinational so the mode register steps on the same edge stable rises.
  assign press       = window_done && btn_s;

  // Bring the asynchronous button into the clock domain.
  // NOTE: non-blocking assignments make sync1 -> btn_s a true two-stage shift;
  // blocking ones would collapse both flops into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn;
      btn_s <= sync1;
    end
  end

  // Count ms ticks while the input disagrees with the accepted state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (btn_s == stable) begin
      cnt <= '0;
    end else if (window_done) begin
      stable <= btn_s;
      cnt    <= '0;
    end else if (tick_ms) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/blinky_mode_ctrl.sv
// LED mode sequencer: ms time base, debounced button stepping a five-mode
// FSM, a 1000 ms phase counter and the registered LED pattern output.
module blinky_mode_ctrl
  import blinky_pkg::*;
#(
  parameter int clk_freq_hz = 100_000_000,
  parameter int debounce_ms = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       q,
  output logic [2:0] mode
);

  localparam int                  TICK_CYCLES = clk_freq_hz / 1000;
  localparam int                  PRESC_W     = $clog2(TICK_CYCLES);
  localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(TICK_CYCLES - 1);

  logic [PRESC_W-1:0] presc;
  logic               tick_ms;
  logic               press;
  logic [9:0]         phase;
  logic [7:0]         fast_cnt;

  assign tick_ms = (presc == PRESC_LAST);

  // Millisecond prescaler, wraps to 0 after the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       presc <= '0;
    else if (tick_ms) presc <= '0;
    else              presc <= presc + 1'b1;
  end

  blinky_debounce #(
    .debounce_ms(debounce_ms)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (tick_ms),
    .btn     (btn),
    .press   (press)
  );

  // Mode FSM advances once per debounced press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     mode <= MODE_OFF;
    else if (press) mode <= next_mode(mode);
  end

  // Phase and FAST sub-counter; a mode change wins over a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= '0;
      fast_cnt <= '0;
    end else if (press) begin
      phase    <= '0;
      fast_cnt <= '0;
    end else if (tick_ms) begin
      phase    <= (phase == PHASE_LAST) ? 10'd0 : phase + 10'd1;
      fast_cnt <= (fast_cnt == FAST_LAST) ? 8'd0 : fast_cnt + 8'd1;
    end
  end

  // Register the LED level derived from the current mode and phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= led_pattern(mode, phase, fast_cnt);
  end

endmodule

// File: tb/tb_blinky_mode_ctrl.sv
// Directed bench for blinky_mode_ctrl at 10 cycles/ms, 3 ms debounce.
// Tick edges fall at cycle counts 10, 20, ... after reset release, so the
// mode-change edge of each press is computed from when btn rises.
module tb_blinky_mode_ctrl;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn   = 1'b0;
  logic       q;
  logic [2:0] mode;

  int cyc;
  int c0;
  int n_checks = 0;
  int n_fail   = 0;

  blinky_mode_ctrl #(
    .clk_freq_hz (10_000),
    .debounce_ms (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .q     (q),
    .mode  (mode)
  );

  always #5 clk = ~clk;

  // Edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Sample q mid-way through ms k after the last mode change.
  task automatic at_ms(input int k, input string tag, input logic exp);
    wait_until(c0 + 10 * k + 5);
    check(tag, q, exp);
  endtask

  // Optional 15-cycle bounce, then hold btn high; mode must step on the
  // third tick after btn_s rises (btn_s lags btn by two edges).
  task automatic press(input string tag, input logic [2:0] old_m,
                       input logic [2:0] new_m, input int n_bounce);
    int k0;
    int e;
    for (int i = 0; i < n_bounce; i++) begin
      btn = 1'b1;
      repeat (15) @(negedge clk);
      btn = 1'b0;
      repeat (15) @(negedge clk);
      check({tag, "_bounce"}, mode, old_m);
    end
    btn = 1'b1;
    k0  = cyc;
    e   = ((k0 + 2) / 10 + 1) * 10 + 20;
    wait_until(e - 1);
    check({tag, "_pre"}, mode, old_m);
    wait_until(e);
    check({tag, "_step"}, mode, new_m);
    c0 = e;
  endtask

  initial begin
    // Reset held for 5 cycles, then 100 ms idle.
    repeat (5) @(negedge clk);
    check("rst_q", q, 1'b0);
    check("rst_mode", mode, 3'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      repeat (10) @(negedge clk);
      check("idle_q", q, 1'b0);
      check("idle_mode", mode, 3'd0);
    end

    // Clean 10 ms press into SLOW.
    press("slow", 3'd0, 3'd1, 0);
    check("slow_q_old", q, 1'b0);
    at_ms(0, "slow_0", 1'b1);
    wait_until(c0 + 100);
    btn = 1'b0;
    at_ms(250,  "slow_250",  1'b1);
    at_ms(499,  "slow_499",  1'b1);
    at_ms(500,  "slow_500",  1'b0);
    at_ms(750,  "slow_750",  1'b0);
    at_ms(999,  "slow_999",  1'b0);
    at_ms(1000, "slow_1000", 1'b1);
    at_ms(1499, "slow_1499", 1'b1);
    check("slow_one_step", mode, 3'd1);

    // FAST, held through the checks: holding gives no further steps.
    press("fast", 3'd1, 3'd2, 0);
    at_ms(0,   "fast_0",   1'b1);
    at_ms(124, "fast_124", 1'b1);
    at_ms(125, "fast_125", 1'b0);
    at_ms(249, "fast_249", 1'b0);
    at_ms(250, "fast_250", 1'b1);
    at_ms(374, "fast_374", 1'b1);
    at_ms(375, "fast_375", 1'b0);
    check("fast_hold", mode, 3'd2);
    btn = 1'b0;
    repeat (60) @(negedge clk);

    press("heart", 3'd2, 3'd3, 0);
    at_ms(0, "heart_0", 1'b1);
    btn = 1'b0;
    at_ms(99,  "heart_99",  1'b1);
    at_ms(100, "heart_100", 1'b0);
    at_ms(199, "heart_199", 1'b0);
    at_ms(200, "heart_200", 1'b1);
    at_ms(299, "heart_299", 1'b1);
    at_ms(300, "heart_300", 1'b0);
    at_ms(999, "heart_999", 1'b0);

    press("on", 3'd3, 3'd4, 0);
    at_ms(0, "on_0", 1'b1);
    btn = 1'b0;
    at_ms(200, "on_200", 1'b1);

    press("off", 3'd4, 3'd0, 0);
    at_ms(0, "off_0", 1'b0);
    btn = 1'b0;
    at_ms(200, "off_200", 1'b0);

    // Bouncing press: 1.5 ms glitches never reach the 3 ms window.
    press("bounce", 3'd0, 3'd1, 6);
    at_ms(0, "bounce_0", 1'b1);
    btn = 1'b0;
    at_ms(300, "bounce_300", 1'b1);
    at_ms(600, "bounce_600", 1'b0);

    // Press whose step lands on the tick leaving phase 700.
    wait_until(c0 + 6985);
    press("collide", 3'd1, 3'd2, 0);
    check("collide_q_old", q, 1'b0);
    @(negedge clk);
    check("collide_q_new", q, 1'b1);
    btn = 1'b0;
    at_ms(124, "collide_124", 1'b1);
    at_ms(125, "collide_125", 1'b0);

    // Reset in HEART at phase 50.
    press("heart2", 3'd2, 3'd3, 0);
    btn = 1'b0;
    at_ms(50, "heart2_50", 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_q", q, 1'b0);
    check("async_rst_mode", mode, 3'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      repeat (50) @(negedge clk);
      check("post_rst_q", q, 1'b0);
      check("post_rst_mode", mode, 3'd0);
    end
    press("restart", 3'd0, 3'd1, 0);
    at_ms(0, "restart_0", 1'b1);
    btn = 1'b0;
    at_ms(499, "restart_499", 1'b1);
    at_ms(500, "restart_500", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
